step_cpu_core: RTL and testbench
================================

STEP_CPU_CORE -- requirements
Module: step_cpu_core

Interface
REQ-001 Parameter DATA_W, default 8, register and datapath width in bits (4..32).
REQ-002 Parameter NREGS, default 4, register count; power of two, 4..16; REG_AW = log2(NREGS).
REQ-003 Parameter INSTR_W, derived, 4 + 2*REG_AW; not overridable.
REQ-004 clk  input  1  single system clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 step  input  1  one-cycle pulse requesting execution of one instruction (debounced upstream).
REQ-007 instr  input  INSTR_W  [3:0] opcode, [3+REG_AW:4] dst, [INSTR_W-1:4+REG_AW] src.
REQ-008 pc  output  DATA_W  current value of r0 (program counter).
REQ-009 disp  output  DATA_W  current value of r[NREGS-1] (LED display register).
REQ-010 flags  output  3  {N, C, Z} flag register.
REQ-011 busy  output  1  high while an instruction is in flight.
REQ-012 done  output  1  one-cycle pulse on the write-back cycle.

Function
REQ-013 The block SHALL implement a four-state FSM: IDLE, FETCH, EXEC, WB.
REQ-014 IDLE -> FETCH when step=1; FETCH -> EXEC; EXEC -> WB; WB -> IDLE, unconditionally.
REQ-015 In FETCH, instr SHALL be latched; later changes to instr SHALL not affect the in-flight instruction.
REQ-016 In EXEC, operands r[dst] (A) and r[src] (B) SHALL be read and the ALU result and flags registered.
REQ-017 In WB, the result SHALL be written to r[dst] and done asserted for exactly that cycle.
REQ-018 busy SHALL be high in FETCH, EXEC and WB, and low in IDLE.
REQ-019 step pulses while busy=1 SHALL be ignored (not queued).
REQ-020 Latency: step sampled at edge t -> result visible on outputs after edge t+3.
REQ-021 Opcodes: 0 NOP, 1 ADD A+B, 2 SUB A-B, 3 AND, 4 OR, 5 XOR, 6 MOV B, 7 INC A+1, 8 DEC A-1, 9 SHL A<<1, A SHR A>>1 logical, B CMP (A-B flags only, no write); C..F reserved, behave as NOP.
REQ-022 All arithmetic SHALL be modulo 2^DATA_W (wrap-around, no saturation).
REQ-023 C SHALL be carry-out for ADD/INC, borrow (A<B unsigned) for SUB/CMP/DEC, and shifted-out bit for SHL/SHR; C SHALL be 0 for logic ops and MOV.
REQ-024 Z = (result == 0) and N = result MSB for every opcode except NOP and reserved opcodes, which leave flags unchanged.
REQ-025 NOP, CMP and reserved opcodes SHALL perform no register write.
REQ-026 In WB, r0 SHALL increment by 1 (modulo 2^DATA_W) unless the instruction writes r0, in which case the written value wins and no increment occurs.
REQ-027 dst = src SHALL be legal; both operands read the same pre-write value.

Reset
REQ-028 rst_n low SHALL immediately force all registers, flags, pc, disp to 0, FSM to IDLE, busy=0, done=0, regardless of state.
REQ-029 A step coincident with the first rising clk edge after rst_n deasserts SHALL be ignored.

Structure
REQ-030 Package step_cpu_pkg SHALL hold the opcode constants, FSM state encoding and flag bit indices.
REQ-031 The ALU SHALL be a separate combinational sub-module step_cpu_alu (inputs op, A, B; outputs result, C, write-enable, flag-update-enable).
REQ-032 Register file SHALL be a flat NREGS x DATA_W array inside step_cpu_core; no memory primitives.

Verification
REQ-033 Defaults, after reset: MOV-free path: step with ADD r1,r1 (r1=0) -> r1=0, Z=1, C=0, pc=1, done 3 cycles after step.
REQ-034 INC r3 x 255 then INC r3 -> disp=0xFF then 0x00 with C=1, Z=1; pc wraps 0xFF->0x00 after 256 steps.
REQ-035 r1=5, r2=7, SUB r1,r2 -> r1=0xFE, C=1, N=1, Z=0; CMP r2,r2 -> r2 unchanged, Z=1, C=0.
REQ-036 MOV r0,r2 with r2=0x40 -> pc=0x40 (no +1); step pulses during busy -> ignored, pc advances once.
REQ-037 rst_n asserted during EXEC of ADD -> all outputs 0 immediately, no write occurs, next step executes normally.
REQ-038 DATA_W=16, NREGS=8: SHL r7 with r7=0x8001 -> disp=0x0002, C=1, N=0.

Source files
------------

// File: rtl/step_cpu_pkg.sv
// Shared definitions for the single-step teaching CPU: opcodes, FSM states and flag bit positions.
package step_cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_MOV = 4'h6;
    localparam logic [3:0] OP_INC = 4'h7;
    localparam logic [3:0] OP_DEC = 4'h8;
    localparam logic [3:0] OP_SHL = 4'h9;
    localparam logic [3:0] OP_SHR = 4'hA;
    localparam logic [3:0] OP_CMP = 4'hB;

    // Positions inside the {N, C, Z} flag register.
    localparam int FLAG_Z  = 0;
    localparam int FLAG_C  = 1;
    localparam int FLAG_N  = 2;
    localparam int FLAGS_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WB    = 2'd3
    } state_t;

endpackage

// File: rtl/step_cpu_alu.sv
// Combinational ALU: computes the result, carry/borrow/shift-out bit and whether the op writes
// a register or updates the flags.
module step_cpu_alu
    import step_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              wr_en,
    output logic              flag_en
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        result  = a;
        carry   = 1'b0;
        wr_en   = 1'b1;
        flag_en = 1'b1;
        case (op)
            OP_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
            OP_SUB: begin
                result = a - b;
                carry  = (a < b);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_MOV: result = b;
            OP_INC: {carry, result} = {1'b0, a} + {{DATA_W{1'b0}}, 1'b1};
            OP_DEC: begin
                result = a - DATA_W'(1);
                carry  = (a == '0);
            end
            OP_SHL: begin
                result = {a[DATA_W-2:0], 1'b0};
                carry  = a[DATA_W-1];
            end
            OP_SHR: begin
                result = {1'b0, a[DATA_W-1:1]};
                carry  = a[0];
            end
            OP_CMP: begin
                result = a - b;
                carry  = (a < b);
                wr_en  = 1'b0;
            end
            // NOP and the reserved opcodes touch neither registers nor flags.
            default: begin
                wr_en   = 1'b0;
                flag_en = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/step_cpu_core.sv
// Four-state single-step CPU: IDLE -> FETCH -> EXEC -> WB, one instruction per step pulse.
// r0 doubles as the program counter and r[NREGS-1] drives the display.
module step_cpu_core
    import step_cpu_pkg::*;
#(
    parameter int  DATA_W  = 8,
    parameter int  NREGS   = 4,
    localparam int REG_AW  = $clog2(NREGS),
    localparam int INSTR_W = 4 + 2 * REG_AW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               step,
    input  logic [INSTR_W-1:0] instr,
    output logic [DATA_W-1:0]  pc,
    output logic [DATA_W-1:0]  disp,
    output logic [FLAGS_W-1:0] flags,
    output logic               busy,
    output logic               done
);

    state_t              state;
    logic                armed;
    logic [INSTR_W-1:0]  instr_q;
    logic [DATA_W-1:0]   regs [NREGS];
    logic [DATA_W-1:0]   res_q;
    logic                wr_q;
    logic [FLAGS_W-1:0]  flags_q;

    logic [3:0]          op;
    logic [REG_AW-1:0]   dst;
    logic [REG_AW-1:0]   src;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_carry;
    logic                alu_wr;
    logic                alu_flag;

    assign op  = instr_q[3:0];
    assign dst = instr_q[3+REG_AW:4];
    assign src = instr_q[INSTR_W-1:4+REG_AW];

    step_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op      (op),
        .a       (regs[dst]),
        .b       (regs[src]),
        .result  (alu_res),
        .carry   (alu_carry),
        .wr_en   (alu_wr),
        .flag_en (alu_flag)
    );

    // armed stays low for the first edge after reset so a step already present then is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            armed   <= 1'b0;
            instr_q <= '0;
            res_q   <= '0;
            wr_q    <= 1'b0;
            flags_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register see pre-edge values, as hardware does.
            armed <= 1'b1;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (step && armed) begin
                        state <= ST_FETCH;
                        busy  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    instr_q <= instr;
                    state   <= ST_EXEC;
                end
                ST_EXEC: begin
                    res_q <= alu_res;
                    wr_q  <= alu_wr;
                    if (alu_flag) begin
                        flags_q[FLAG_N] <= alu_res[DATA_W-1];
                        flags_q[FLAG_C] <= alu_carry;
                        flags_q[FLAG_Z] <= (alu_res == '0);
                    end
                    state <= ST_WB;
                    done  <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // A write to r0 replaces the automatic program-counter increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the register file is a handful of flops, not a RAM, so it is cleared on reset.
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (state == ST_WB) begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_q && (dst == REG_AW'(i))) begin
                    regs[i] <= res_q;
                end else if (i == 0) begin
                    regs[i] <= regs[i] + DATA_W'(1);
                end
            end
        end
    end

    assign pc    = regs[0];
    assign disp  = regs[NREGS-1];
    assign flags = flags_q;

endmodule

// File: tb/tb_step_cpu_core.sv
// Bench for step_cpu_core: an arithmetic reference model checked every cycle on the default
// configuration, plus a directed run on a 16-bit, 8-register instance.
module tb_step_cpu_core;

    logic        clk;
    logic        rst_n;
    logic        step;
    logic [7:0]  instr;
    logic [7:0]  pc, disp;
    logic [2:0]  flags;
    logic        busy, done;

    logic        step16;
    logic [9:0]  instr16;
    logic [15:0] pc16, disp16;
    logic [2:0]  flags16;
    logic        busy16, done16;

    int n_checks = 0;
    int n_err    = 0;

    // Reference state for the 8-bit instance.
    int m_regs [4];
    int m_flags;
    bit exp_busy;
    bit exp_done;
    bit chk_en;

    localparam int MASK = 255;

    step_cpu_core u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (step),
        .instr (instr),
        .pc    (pc),
        .disp  (disp),
        .flags (flags),
        .busy  (busy),
        .done  (done)
    );

    step_cpu_core #(.DATA_W(16), .NREGS(8)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (step16),
        .instr (instr16),
        .pc    (pc16),
        .disp  (disp16),
        .flags (flags16),
        .busy  (busy16),
        .done  (done16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("pc",    32'(pc),    32'(m_regs[0]));
            check("disp",  32'(disp),  32'(m_regs[3]));
            check("flags", 32'(flags), 32'(m_flags));
            check("busy",  32'(busy),  32'(exp_busy));
            check("done",  32'(done),  32'(exp_done));
        end
    end

    // Instruction semantics in plain integer arithmetic on 8-bit values.
    function automatic void model_alu(input int op, input int a, input int b,
                                      output int res, output int c, output bit wr, output bit fu);
        wr  = 1'b1;
        fu  = 1'b1;
        c   = 0;
        res = a;
        case (op)
            1:  begin res = a + b; c = (res > MASK) ? 1 : 0; end
            2:  begin res = a - b; c = (a < b) ? 1 : 0; end
            3:  res = a & b;
            4:  res = a | b;
            5:  res = a ^ b;
            6:  res = b;
            7:  begin res = a + 1; c = (res > MASK) ? 1 : 0; end
            8:  begin res = a - 1; c = (a == 0) ? 1 : 0; end
            9:  begin res = a * 2; c = (a >= 128) ? 1 : 0; end
            10: begin res = a / 2; c = a % 2; end
            11: begin res = a - b; c = (a < b) ? 1 : 0; wr = 1'b0; end
            default: begin wr = 1'b0; fu = 1'b0; end
        endcase
        res = res & MASK;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 0;
        m_flags  = 0;
        exp_busy = 1'b0;
        exp_done = 1'b0;
    endfunction

    // One instruction on the 8-bit instance; extra=1 holds step high through the busy cycles.
    task automatic step8(input logic [3:0] op, input int dst, input int src, input bit extra);
        int a, b, res, c;
        bit wr, fu;
        @(posedge clk); #2;
        step  = 1'b1;
        instr = {2'(src), 2'(dst), op};
        @(posedge clk); #2;
        step     = extra;
        exp_busy = 1'b1;
        a = m_regs[dst];
        b = m_regs[src];
        model_alu(int'(op), a, b, res, c, wr, fu);
        @(posedge clk); #2;
        instr = 8'($urandom);
        @(posedge clk); #2;
        exp_done = 1'b1;
        if (fu) m_flags = ((res >= 128) ? 4 : 0) + c * 2 + ((res == 0) ? 1 : 0);
        @(posedge clk); #2;
        step     = 1'b0;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        if (wr) m_regs[dst] = res;
        if (!(wr && dst == 0)) m_regs[0] = (m_regs[0] + 1) & MASK;
    endtask

    task automatic step_16(input logic [3:0] op, input int dst, input int src);
        bit seen;
        @(posedge clk); #2;
        step16  = 1'b1;
        instr16 = {3'(src), 3'(dst), op};
        @(posedge clk); #2;
        step16 = 1'b0;
        seen   = 1'b0;
        for (int n = 0; n < 8 && !seen; n++) begin
            @(negedge clk);
            if (done16) seen = 1'b1;
        end
        if (!seen) check("done16_timeout", 32'(seen), 32'd1);
        @(posedge clk); #2;
    endtask

    typedef struct {
        logic [3:0] op;
        int         dst;
        int         src;
    } vec_t;

    vec_t vecs [12] = '{
        '{4'h3, 3, 2},   // AND 0xFE & 7
        '{4'h4, 3, 1},   // OR
        '{4'h5, 3, 2},   // XOR
        '{4'hA, 3, 3},   // SHR
        '{4'h9, 3, 3},   // SHL
        '{4'h8, 3, 3},   // DEC
        '{4'h0, 3, 1},   // NOP
        '{4'hC, 1, 2},   // reserved
        '{4'hF, 3, 3},   // reserved
        '{4'h1, 3, 1},   // ADD with carry-out
        '{4'h5, 1, 1},   // XOR self -> 0
        '{4'h8, 1, 1}    // DEC from 0 -> borrow
    };

    initial begin
        rst_n   = 1'b0;
        step    = 1'b0;
        instr   = '0;
        step16  = 1'b0;
        instr16 = '0;
        chk_en  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        check("rst_pc",    32'(pc),    32'd0);
        check("rst_disp",  32'(disp),  32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        chk_en = 1'b1;

        step8(4'h1, 1, 1, 1'b0);
        check("add_zero_pc",    32'(pc),    32'd1);
        check("add_zero_flags", 32'(flags), 32'b001);

        repeat (5) step8(4'h7, 1, 0, 1'b0);
        repeat (7) step8(4'h7, 2, 0, 1'b0);
        check("pc_13", 32'(pc), 32'd13);
        step8(4'h2, 1, 2, 1'b0);
        check("sub_flags", 32'(flags), 32'b110);
        step8(4'hB, 2, 2, 1'b0);
        check("cmp_flags", 32'(flags), 32'b001);
        step8(4'h6, 3, 1, 1'b0);
        check("sub_result", 32'(disp), 32'hFE);

        foreach (vecs[i]) step8(vecs[i].op, vecs[i].dst, vecs[i].src, 1'b0);

        step8(4'h5, 2, 2, 1'b0);
        step8(4'h7, 2, 0, 1'b0);
        repeat (6) step8(4'h9, 2, 2, 1'b0);
        step8(4'h6, 0, 2, 1'b1);
        check("mov_pc", 32'(pc), 32'h40);

        step8(4'h5, 3, 3, 1'b0);
        repeat (255) step8(4'h7, 3, 0, 1'b0);
        check("inc_ff", 32'(disp), 32'hFF);
        step8(4'h7, 3, 0, 1'b0);
        check("inc_wrap",       32'(disp),  32'h00);
        check("inc_wrap_flags", 32'(flags), 32'b011);
        check("pc_wrap",        32'(pc),    32'h41);

        // Reset lands in EXEC of an ADD.
        @(posedge clk); #2;
        step  = 1'b1;
        instr = {2'd2, 2'd3, 4'h1};
        @(posedge clk); #2;
        step     = 1'b0;
        exp_busy = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_pc",    32'(pc),    32'd0);
        check("mid_rst_disp",  32'(disp),  32'd0);
        check("mid_rst_flags", 32'(flags), 32'd0);
        check("mid_rst_busy",  32'(busy),  32'd0);
        check("mid_rst_done",  32'(done),  32'd0);
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst_n = 1'b1;
        step  = 1'b1;
        instr = {2'd0, 2'd1, 4'h7};
        @(posedge clk); #2;
        step = 1'b0;
        check("step_at_release_ignored", 32'(busy), 32'd0);
        step8(4'h7, 1, 0, 1'b0);
        check("post_rst_pc",    32'(pc),    32'd1);
        check("post_rst_flags", 32'(flags), 32'b000);
        chk_en = 1'b0;

        step_16(4'h7, 7, 0);
        step_16(4'h7, 1, 0);
        repeat (15) step_16(4'h9, 1, 1);
        step_16(4'h4, 7, 1);
        check("w16_disp_8001", 32'(disp16), 32'h8001);
        step_16(4'h9, 7, 7);
        check("w16_shl_disp",  32'(disp16),  32'h0002);
        check("w16_shl_flags", 32'(flags16), 32'b010);
        check("w16_pc",        32'(pc16),    32'd19);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
